// File: rtl/cic_channel_drain_if.sv
// Bundle between the drain sequencer, the CIC comb-output RAM read port and
// the sample stream toward the mic-array FIFO. The drain side is the master.
interface cic_channel_drain_if #(
    parameter int WIDTH     = 22,
    parameter int CHANNELS  = 8,
    parameter int OUT_WIDTH = 16
);
    localparam int CW = $clog2(CHANNELS);

    logic                 rd_en;
    logic [CW-1:0]        rd_addr;
    logic [WIDTH-1:0]     rd_data;
    logic [OUT_WIDTH-1:0] out_data;
    logic [CW-1:0]        out_channel;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output rd_en, rd_addr, out_data, out_channel, out_last, out_valid,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, out_data, out_channel, out_last, out_valid,
        output rd_data, out_ready
    );
endinterface

// File: rtl/cic_channel_drain.sv
// Walks the per-channel CIC output buffer once per frame strobe, scaling and
// saturating each word and presenting it on a valid/ready stream.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  S_IDLE    | waiting for enable & frame_strobe
//  S_READ    | RAM read issued for the current channel
//  S_WAIT    | RAM data valid; scaled sample captured on the exiting edge
//  S_PRESENT | sample offered on the stream until accepted
module cic_channel_drain #(
    parameter int WIDTH     = 22,
    parameter int CHANNELS  = 8,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 6
) (
    input  logic                       clk,
    input  logic                       resetn,   // active-high despite the name
    input  logic                       enable_i,
    input  logic                       frame_strobe_i,
    output logic                       overrun_o,
    cic_channel_drain_if.master        bus
);
    localparam int CW = $clog2(CHANNELS);
    localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);
    // One guard bit above the wider of input/output keeps the clamp compare exact.
    localparam int EW = ((WIDTH > OUT_WIDTH) ? WIDTH : OUT_WIDTH) + 1;
    localparam logic signed [EW-1:0] SAT_MAX =
        {{(EW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN =
        {{(EW - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_PRESENT} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        channel_q, channel_d;
    logic                 overrun_q, overrun_d;
    logic                 capture;
    logic [OUT_WIDTH-1:0] out_data_q;
    logic [CW-1:0]        out_channel_q;
    logic                 out_last_q;
    logic signed [WIDTH-1:0] shifted;
    logic signed [EW-1:0]    shifted_ext;
    logic [OUT_WIDTH-1:0]    sat_value;

    // Sign-preserving scale, then clamp into the output range.
    always_comb begin
        shifted     = $signed(bus.rd_data) >>> SHIFT;
        shifted_ext = {{(EW - WIDTH){shifted[WIDTH-1]}}, shifted};
        sat_value   = shifted_ext[OUT_WIDTH-1:0];
        if (shifted_ext > SAT_MAX) begin
            sat_value = SAT_MAX[OUT_WIDTH-1:0];
        end else if (shifted_ext < SAT_MIN) begin
            sat_value = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

    // Next-state logic; a late strobe only flags overrun, it never restarts the walk.
    always_comb begin
        state_d   = state_q;
        channel_d = channel_q;
        overrun_d = overrun_q;
        capture   = 1'b0;
        if (!enable_i) begin
            state_d   = S_IDLE;
            channel_d = '0;
            overrun_d = 1'b0;
        end else begin
            if (frame_strobe_i && (state_q != S_IDLE)) begin
                overrun_d = 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (frame_strobe_i) begin
                        state_d   = S_READ;
                        channel_d = '0;
                    end
                end
                S_READ: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    capture = 1'b1;
                    state_d = S_PRESENT;
                end
                S_PRESENT: begin
                    if (bus.out_ready) begin
                        if (channel_q == LAST_CH) begin
                            channel_d = '0;
                            state_d   = S_IDLE;
                        end else begin
                            channel_d = channel_q + CW'(1);
                            state_d   = S_READ;
                        end
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    channel_d = '0;
                end
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q   <= S_IDLE;
            channel_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            channel_q <= channel_d;
            overrun_q <= overrun_d;
        end
    end

    // Output sample register; held while the consumer stalls.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            out_data_q    <= '0;
            out_channel_q <= '0;
            out_last_q    <= 1'b0;
        end else if (capture && enable_i) begin
            out_data_q    <= sat_value;
            out_channel_q <= channel_q;
            out_last_q    <= (channel_q == LAST_CH);
        end
    end

    assign bus.rd_en       = (state_q == S_READ);
    assign bus.rd_addr     = channel_q;
    assign bus.out_valid   = (state_q == S_PRESENT);
    assign bus.out_data    = out_data_q;
    assign bus.out_channel = out_channel_q;
    assign bus.out_last    = out_last_q && (state_q == S_PRESENT);
    assign overrun_o       = overrun_q;
endmodule
